uart_frame_checker: RTL
=======================

Name: uart_frame_checker

Overview:
- Parametrised receive-side frame checker for the UART receiver.
- Consumes one sampled bit per strobe from the receiver's bit sampler.
- Tracks frame position through start, data, optional parity and 1 or 2 stop bits.
- Returns assembled data plus parity, framing (stop) and break status, and keeps saturating error counters for the status path.

Parameters:
- DATA_BITS, 8, data bits per frame; legal 5..9.
- PARITY_MODE, 0, parity setting: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, stop bits per frame; legal 1 or 2.
- CNT_WIDTH, 8, width of each error counter.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- bit_valid  in  1  one-cycle strobe; bit_value holds the mid-bit sample.
- bit_value  in  1  sampled serial line level.
- abort  in  1  synchronous frame abandon; returns to IDLE.
- cnt_clear  in  1  synchronous clear of both error counters.
- busy  out  1  high while in any state other than IDLE.
- data_out  out  DATA_BITS  last completed frame's data, LSB = first data bit received.
- frame_valid  out  1  one-cycle pulse on frame completion.
- parity_error  out  1  parity status of the last completed frame.
- stop_error  out  1  framing status of the last completed frame.
- break_detect  out  1  break status of the last completed frame.
- frame_err_cnt  out  CNT_WIDTH  saturating count of frames with stop_error.
- parity_err_cnt  out  CNT_WIDTH  saturating count of frames with parity_error.

Behaviour:
- Reset (rst_n low, async):
  - State is IDLE.
  - All outputs are 0, including data_out and both counters.
  - Shift register, bit index and accumulated flags are cleared.
- States: IDLE, DATA, PARITY, STOP.
  - The FSM advances only on cycles with bit_valid = 1; it holds otherwise.
- IDLE:
  - bit_valid with bit_value = 0 (start bit) -> DATA, bit index = 0.
  - bit_valid with bit_value = 1 -> stay IDLE, no output change (glitch rejected).
- DATA:
  - Each strobe shifts bit_value in, LSB first.
  - After the DATA_BITS-th bit: go to PARITY if PARITY_MODE != 0, else STOP.
- PARITY:
  - Compute the XOR of the data bits and the parity bit.
  - Error if the XOR is 1 in even mode or 0 in odd mode.
  - Next state is STOP.
- STOP:
  - Accepts exactly STOP_BITS strobes.
  - Any stop bit sampled 0 sets the frame's stop error.
  - All stop bits are consumed even after a 0.
- Completion (final stop strobe accepted):
  - On the next rising edge: frame_valid pulses for 1 cycle.
  - data_out, parity_error, stop_error and break_detect update together on that edge.
  - The FSM returns to IDLE on the same edge.
  - Latency: 1 cycle from the final stop strobe to frame_valid.
- Status holding: data_out and the three status flags hold until the next completion or reset.
  - They are meaningful only when qualified by frame_valid.
- Break: break_detect = 1 when all data bits, the parity bit (if present) and the first stop bit are 0.
  - break_detect implies stop_error = 1.
- PARITY_MODE = 0: parity_error is always 0.
- Back-to-back frames: a bit_valid start bit in the cycle frame_valid is high is accepted (the FSM is already IDLE).
- abort:
  - Any state -> IDLE on the next edge.
  - No frame_valid; outputs and counters are unchanged.
  - abort has priority over bit_valid in the same cycle.
- Counters:
  - Increment by 1 on the completion edge when the corresponding flag is set.
  - Saturate at 2^CNT_WIDTH-1.
  - cnt_clear has priority over a coincident increment: the result is 0.
- Mid-frame reset: immediate return to the reset state; the partial frame is discarded.

Test Plan:
- Defaults, frame start 0, data 0xA5 LSB-first, stop 1 -> one cycle later frame_valid = 1, data_out = 0xA5, stop_error = 0, parity_error = 0, counters 0.
- PARITY_MODE = 1, data 0x07 with parity bit 0 -> parity_error = 1, parity_err_cnt = 1; repeat with parity bit 1 -> parity_error = 0, count stays 1.
- STOP_BITS = 2, data 0x3C, stops 1 then 0 -> stop_error = 1, break_detect = 0, frame_err_cnt = 1, frame_valid asserted only after the second stop strobe.
- Data 0x00, stop 0 -> stop_error = 1, break_detect = 1; a following clean frame 0x55 clears both flags.
- IDLE bit_valid with bit_value = 1 -> busy stays 0, no frame_valid. abort after 3 data bits -> IDLE, no frame_valid, next frame 0x81 received correctly.
- CNT_WIDTH = 2, drive 5 framing-error frames -> frame_err_cnt saturates at 3; cnt_clear coincident with a 6th error -> counter reads 0.

Source files
------------

// File: rtl/uart_frame_checker.sv
// UART receive-side frame checker: walks start, data, optional parity and stop bits
// one sampler strobe at a time, then reports data, status flags and saturating error counts.
module uart_frame_checker #(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 bit_valid,
  input  logic                 bit_value,
  input  logic                 abort,
  input  logic                 cnt_clear,
  output logic                 busy,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 frame_valid,
  output logic                 parity_error,
  output logic                 stop_error,
  output logic                 break_detect,
  output logic [CNT_WIDTH-1:0] frame_err_cnt,
  output logic [CNT_WIDTH-1:0] parity_err_cnt
);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t               state, state_nxt;
  logic [3:0]           bit_idx;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 par_acc;
  logic                 zero_acc;
  logic                 stop_err_acc;
  logic                 brk_acc;
  logic                 stop_idx;
  logic                 strobe;
  logic                 last_data;
  logic                 last_stop;
  logic                 par_err_fin;
  logic                 stop_err_fin;
  logic                 brk_fin;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] cnt,
                                                   input logic              inc);
    if (inc && !(&cnt)) return cnt + CNT_WIDTH'(1);
    return cnt;
  endfunction

  assign strobe    = bit_valid && !abort;
  assign last_data = (bit_idx == 4'(DATA_BITS - 1));
  assign last_stop = strobe && (state == STOP) && ((STOP_BITS == 1) || stop_idx);
  assign busy      = (state != IDLE);

  // Frame verdicts as they stand including the stop bit currently on bit_value
  assign stop_err_fin = stop_err_acc || !bit_value;
  assign brk_fin      = stop_idx ? brk_acc : (zero_acc && !bit_value);
  assign par_err_fin  = (PARITY_MODE == 1) ? par_acc :
                        (PARITY_MODE == 2) ? !par_acc : 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else if (bit_valid) begin
      case (state)
        IDLE:    if (!bit_value) state_nxt = DATA;
        DATA:    if (last_data) state_nxt = (PARITY_MODE != 0) ? PARITY : STOP;
        PARITY:  state_nxt = STOP;
        STOP:    if (last_stop) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_idx      <= '0;
      shift_reg    <= '0;
      par_acc      <= 1'b0;
      zero_acc     <= 1'b0;
      stop_err_acc <= 1'b0;
      brk_acc      <= 1'b0;
      stop_idx     <= 1'b0;
    end else if (strobe) begin
      case (state)
        IDLE: begin
          bit_idx      <= '0;
          par_acc      <= 1'b0;
          zero_acc     <= 1'b1;
          stop_err_acc <= 1'b0;
          brk_acc      <= 1'b0;
          stop_idx     <= 1'b0;
        end
        DATA: begin
          shift_reg <= {bit_value, shift_reg[DATA_BITS-1:1]};
          bit_idx   <= bit_idx + 4'd1;
          par_acc   <= par_acc ^ bit_value;
          zero_acc  <= zero_acc && !bit_value;
        end
        PARITY: begin
          par_acc  <= par_acc ^ bit_value;
          zero_acc <= zero_acc && !bit_value;
        end
        STOP: begin
          stop_err_acc <= stop_err_fin;
          brk_acc      <= brk_fin;
          stop_idx     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Completion edge: results, pulse and counters all move together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_valid    <= 1'b0;
      data_out       <= '0;
      parity_error   <= 1'b0;
      stop_error     <= 1'b0;
      break_detect   <= 1'b0;
      frame_err_cnt  <= '0;
      parity_err_cnt <= '0;
    end else begin
      frame_valid <= last_stop;
      if (last_stop) begin
        data_out     <= shift_reg;
        parity_error <= par_err_fin;
        stop_error   <= stop_err_fin;
        break_detect <= brk_fin;
      end
      if (cnt_clear) begin
        frame_err_cnt  <= '0;
        parity_err_cnt <= '0;
      end else begin
        frame_err_cnt  <= sat_inc(frame_err_cnt, last_stop && stop_err_fin);
        parity_err_cnt <= sat_inc(parity_err_cnt, last_stop && par_err_fin);
      end
    end
  end

endmodule
